// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the E stage and the HI/LO multiply-divide unit.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, op, A, B, input busy, HI, LO);
  modport slave  (input start, op, A, B, output busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO unit: mult/multu (5 cycles), div/divu (10 cycles), mthi/mtlo (1 edge).
// Optional madd/maddu (5 cycles) are built only when MULT_DIV_UNIT_MADD_EN is defined.
module mult_div_unit (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MADD  = 3'b110,
    OP_MADDU = 3'b111
  } op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [3:0]  lat;
  logic        accept;
  logic        finish;
  logic        start_ok;
  op_e         op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q, hi_nx, lo_nx;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo_s, rem_s;

  // start_ok is low for the first edge after reset release, so a start
  // coinciding with release is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      start_ok <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      start_ok <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    lat      = '0;
    case (bus.op)
      OP_MULT, OP_MULTU: lat = 4'd5;
      OP_DIV,  OP_DIVU:  lat = 4'd10;
`ifdef MULT_DIV_UNIT_MADD_EN
      OP_MADD, OP_MADDU: lat = 4'd5;
`endif
      default:           lat = '0;
    endcase
    case (state)
      IDLE: begin
        if (bus.start && start_ok) begin
          accept = 1'b1;
          if (lat != '0) begin
            state_nx = RUN;
            cnt_nx   = lat;
          end
        end
      end
      RUN: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    finish   = (state == RUN) && (cnt == 4'd1);
  end

  // Signed division via magnitudes: avoids the overflow corner of
  // 0x80000000 / -1 and yields the truncate-toward-zero rules directly.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    a_mag  = a_q[31] ? (~a_q + 32'd1) : a_q;
    b_mag  = b_q[31] ? (~b_q + 32'd1) : b_q;
    q_mag  = a_mag / b_mag;
    r_mag  = a_mag % b_mag;
    quo_s  = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
    rem_s  = a_q[31] ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    hi_nx = hi_q;
    lo_nx = lo_q;
    if (accept && (bus.op == OP_MTHI)) hi_nx = bus.A;
    if (accept && (bus.op == OP_MTLO)) lo_nx = bus.A;
    if (finish) begin
      case (op_q)
        OP_MULT:  {hi_nx, lo_nx} = prod_s;
        OP_MULTU: {hi_nx, lo_nx} = prod_u;
        OP_DIV: begin
          if (b_q != '0) begin
            lo_nx = quo_s;
            hi_nx = rem_s;
          end
        end
        OP_DIVU: begin
          if (b_q != '0) begin
            lo_nx = a_q / b_q;
            hi_nx = a_q % b_q;
          end
        end
`ifdef MULT_DIV_UNIT_MADD_EN
        OP_MADD:  {hi_nx, lo_nx} = {hi_q, lo_q} + prod_s;
        OP_MADDU: {hi_nx, lo_nx} = {hi_q, lo_q} + prod_u;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= OP_MULT;
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (accept) begin
        op_q <= op_e'(bus.op);
        a_q  <= bus.A;
        b_q  <= bus.B;
      end
      hi_q <= hi_nx;
      lo_q <= lo_nx;
    end
  end

  assign bus.HI = hi_q;
  assign bus.LO = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: arithmetic reference model, randomized ops,
// directed corner cases (div overflow, divide by zero, reset abort, madd wrap).
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if bus();
  mult_div_unit dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int          issue;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          bc = 0;
  int          nops = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;
  string       opn[8] = '{"mult", "multu", "div", "divu", "mthi", "mtlo", "madd", "maddu"};
  logic [31:0] specials[8] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'h7FFF_FFFF, 32'h2, 32'hFFFF_FFF9, 32'h0001_0000};

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Monitor: an entry completes once its start edge has passed and the unit is idle.
  always @(negedge clk) begin
    if (!reset) begin
      bc = 0;
    end else begin
      if (bus.busy) bc++;
      if (sbq.size() > 0 && cyc > sbq[0].issue && !bus.busy) begin
        e = sbq.pop_front();
        chk({e.name, "_busy_cycles"}, 32'(bc), 32'(e.lat));
        chk({e.name, "_HI"}, bus.HI, e.hi);
        chk({e.name, "_LO"}, bus.LO, e.lo);
        bc = 0;
      end
    end
  end

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 1) == 0) return specials[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge where the result is visible.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit stray);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     ps, pu;
    logic [31:0]     nh, nl;
    int              lat;
    string           nm;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    ps = 64'(sa * sb);
    pu = 64'(ua * ub);
    nh = mhi;
    nl = mlo;
    lat = 0;
    case (op)
      3'd0: begin lat = 5; {nh, nl} = ps; end
      3'd1: begin lat = 5; {nh, nl} = pu; end
      3'd2: begin
        lat = 10;
        if (b != 0) begin nl = 32'(sa / sb); nh = 32'(sa % sb); end
      end
      3'd3: begin
        lat = 10;
        if (b != 0) begin nl = a / b; nh = a % b; end
      end
      3'd4: nh = a;
      3'd5: nl = a;
`ifdef MULT_DIV_UNIT_MADD_EN
      3'd6: begin lat = 5; {nh, nl} = {mhi, mlo} + ps; end
      3'd7: begin lat = 5; {nh, nl} = {mhi, mlo} + pu; end
`endif
      default: ;
    endcase
    nops++;
    nm = $sformatf("%s#%0d", opn[op], nops);
    bus.start = 1'b1;
    bus.op = op;
    bus.A = a;
    bus.B = b;
    sbq.push_back('{issue: cyc, lat: lat, hi: nh, lo: nl, name: nm});
    mhi = nh;
    mlo = nl;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      bus.op = 3'($urandom);
      bus.A = $urandom;
      bus.B = $urandom;
      if (stray && k == lat / 2) bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;
    bus.op = '0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) @(negedge clk);
    chk("reset_HI", bus.HI, 32'h0);
    chk("reset_LO", bus.LO, 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(3'd3, 32'd7, 32'd0, 1'b0);
    issue(3'd4, 32'h1234_5678, 32'h0, 1'b0);
    issue(3'd2, 32'd100, 32'd7, 1'b1);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(3'd2, 32'd9, 32'hFFFF_FFFD, 1'b0);

    // Preload HI=LO=1, then reset during the third busy cycle of a mult.
    issue(3'd4, 32'h1, 32'h0, 1'b0);
    issue(3'd5, 32'h1, 32'h0, 1'b0);
    bus.start = 1'b1;
    bus.op = 3'd0;
    bus.A = 32'h7;
    bus.B = 32'h9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_HI", bus.HI, 32'h0);
    chk("abort_LO", bus.LO, 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    mhi = '0;
    mlo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1;
    bus.op = 3'd4;
    bus.A = 32'hDEAD_BEEF;
    sbq.push_back('{issue: cyc, lat: 0, hi: 32'h0, lo: 32'h0, name: "start_at_release"});
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_abort_HI", bus.HI, 32'h0);
    chk("post_abort_LO", bus.LO, 32'h0);
    issue(3'd0, 32'h7, 32'h9, 1'b0);

    issue(3'd4, 32'h0, 32'h0, 1'b0);
    issue(3'd5, 32'hFFFF_FFFF, 32'h0, 1'b0);
    issue(3'd6, 32'h1, 32'h1, 1'b0);
    issue(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    for (int n = 0; n < 40; n++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 3) == 0);
    end

    for (int w = 0; w < 20 && sbq.size() > 0; w++) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
